// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode and ALU-op encodings for the CPU control path, plus a one-hot check helper.
// Pure constants and functions; no latency or flow control involved.
package cpu_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_IO  = 3'd7;

  typedef enum logic [1:0] {
    ALU_NONE    = 2'b00,
    ALU_AND     = 2'b01,
    ALU_ADD     = 2'b10,
    ALU_PASS_DR = 2'b11
  } alu_op_e;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Decodes the latched 3-bit opcode into eight one-hot instruction lines.
// Combinational, zero latency; no backpressure.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] d,
  output logic [7:0] dec
);

  assign dec = 8'd1 << d;

endmodule

// File: rtl/timing_control_unit.sv
// Hardwired control unit: decodes T-state, opcode and flags into micro-operation strobes.
// Control outputs are combinational from t (zero latency); flags update on clk; no backpressure.
module timing_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int IR_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      t,
  input  logic [IR_W-1:0] ir,
  input  logic            dr_zero,
  input  logic            start,
  output logic            sc_clr,
  output logic            ar_ld_pc,
  output logic            ar_ld_ir,
  output logic            ar_ld_mem,
  output logic            ar_inc,
  output logic            ir_ld,
  output logic            pc_inc,
  output logic            pc_ld_ar,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            dr_ld,
  output logic            dr_inc,
  output logic            ac_ld,
  output logic            halted,
  output logic            err,
  output logic [1:0]      alu_op
);

  logic       s_q;
  logic       i_q;
  logic [2:0] d_q;
  logic       err_q;
  logic [7:0] dec;
  logic       t_ok;
  logic       run;
  logic       mem_ref;
  logic       unused_ir;

  opcode_decoder u_dec (
    .d   (d_q),
    .dec (dec)
  );

  assign unused_ir = ^ir[IR_W-5:1];
  assign t_ok      = is_onehot8(t);
  // A malformed t is treated like a latched error in the same cycle so nothing fires on it.
  assign run       = s_q & ~err_q & t_ok;
  assign mem_ref   = dec[OP_AND] | dec[OP_ADD] | dec[OP_LDA];
  assign halted    = ~s_q;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= 1'b1;
      i_q   <= 1'b0;
      d_q   <= 3'd0;
      err_q <= 1'b0;
    end else begin
      if (!t_ok)
        err_q <= 1'b1;
      if (run && t[2]) begin
        i_q <= ir[IR_W-1];
        d_q <= ir[IR_W-2:IR_W-4];
      end
      if (run && t[3] && dec[OP_IO] && !i_q && ir[0])
        s_q <= 1'b0;
      else if (!s_q && start)
        s_q <= 1'b1;
    end
  end

  always_comb begin
    sc_clr    = 1'b0;
    ar_ld_pc  = 1'b0;
    ar_ld_ir  = 1'b0;
    ar_ld_mem = 1'b0;
    ar_inc    = 1'b0;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_ld_ar  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    dr_ld     = 1'b0;
    dr_inc    = 1'b0;
    ac_ld     = 1'b0;
    alu_op    = ALU_NONE;
    if (!run) begin
      sc_clr = 1'b1;
    end else begin
      if (t[0]) ar_ld_pc = 1'b1;
      if (t[1]) begin
        mem_rd = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      if (t[2]) ar_ld_ir = 1'b1;
      if (t[3]) begin
        if (dec[OP_IO]) begin
          sc_clr = 1'b1;
        end else if (i_q) begin
          mem_rd    = 1'b1;
          ar_ld_mem = 1'b1;
        end
      end
      if (t[4]) begin
        if (mem_ref || dec[OP_ISZ]) begin
          mem_rd = 1'b1;
          dr_ld  = 1'b1;
        end
        if (dec[OP_STA]) begin
          mem_wr = 1'b1;
          sc_clr = 1'b1;
        end
        if (dec[OP_BUN]) begin
          pc_ld_ar = 1'b1;
          sc_clr   = 1'b1;
        end
        if (dec[OP_BSA]) begin
          mem_wr = 1'b1;
          ar_inc = 1'b1;
        end
      end
      if (t[5]) begin
        if (mem_ref) begin
          ac_ld  = 1'b1;
          sc_clr = 1'b1;
          alu_op = dec[OP_AND] ? ALU_AND : (dec[OP_ADD] ? ALU_ADD : ALU_PASS_DR);
        end
        if (dec[OP_BSA]) begin
          pc_ld_ar = 1'b1;
          sc_clr   = 1'b1;
        end
        if (dec[OP_ISZ]) dr_inc = 1'b1;
      end
      if (t[6] && dec[OP_ISZ]) begin
        mem_wr = 1'b1;
        sc_clr = 1'b1;
        pc_inc = dr_zero;
      end
      // Overrun guard: no instruction legitimately reaches T7.
      if (t[7]) sc_clr = 1'b1;
    end
  end

endmodule

// File: tb/tb_timing_control_unit.sv
// Directed checks of each instruction class plus a randomized run against a flag-level model.
module tb_timing_control_unit;

  localparam logic [16:0] M_SC    = 17'd1 << 16;
  localparam logic [16:0] M_ARPC  = 17'd1 << 15;
  localparam logic [16:0] M_ARIR  = 17'd1 << 14;
  localparam logic [16:0] M_ARMEM = 17'd1 << 13;
  localparam logic [16:0] M_ARINC = 17'd1 << 12;
  localparam logic [16:0] M_IRLD  = 17'd1 << 11;
  localparam logic [16:0] M_PCINC = 17'd1 << 10;
  localparam logic [16:0] M_PCAR  = 17'd1 << 9;
  localparam logic [16:0] M_RD    = 17'd1 << 8;
  localparam logic [16:0] M_WR    = 17'd1 << 7;
  localparam logic [16:0] M_DRLD  = 17'd1 << 6;
  localparam logic [16:0] M_DRINC = 17'd1 << 5;
  localparam logic [16:0] M_ACLD  = 17'd1 << 4;
  localparam logic [16:0] M_HALT  = 17'd1 << 3;
  localparam logic [16:0] M_ERR   = 17'd1 << 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  t = 8'd1;
  logic [15:0] ir = 16'd0;
  logic        dr_zero = 1'b0;
  logic        start = 1'b0;
  logic sc_clr, ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc, ir_ld, pc_inc, pc_ld_ar;
  logic mem_rd, mem_wr, dr_ld, dr_inc, ac_ld, halted, err;
  logic [1:0] alu_op;
  logic [16:0] obs;

  int compared = 0;
  int mismatched = 0;

  // Model of the architectural flags: run, indirect, opcode, error.
  logic       ms = 1'b1, mi = 1'b0, me = 1'b0;
  logic [2:0] md = 3'd0;

  always #5 clk = ~clk;

  timing_control_unit #(.IR_W(16)) dut (
    .clk(clk), .reset(reset), .t(t), .ir(ir), .dr_zero(dr_zero), .start(start),
    .sc_clr(sc_clr), .ar_ld_pc(ar_ld_pc), .ar_ld_ir(ar_ld_ir), .ar_ld_mem(ar_ld_mem),
    .ar_inc(ar_inc), .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld_ar(pc_ld_ar),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld),
    .halted(halted), .err(err), .alu_op(alu_op)
  );

  assign obs = {sc_clr, ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc, ir_ld, pc_inc, pc_ld_ar,
                mem_rd, mem_wr, dr_ld, dr_inc, ac_ld, halted, err, alu_op};

  function automatic logic [16:0] exp_vec(input logic s, input logic i, input logic e,
                                          input logic [2:0] d, input logic [7:0] tv,
                                          input logic drz);
    logic [16:0] v;
    int k;
    v = 17'd0;
    v[3] = ~s;
    v[2] = e;
    if (!s || e || !$onehot(tv)) return v | M_SC;
    k = 0;
    for (int b = 0; b < 8; b++) if (tv[b]) k = b;
    case (k)
      0: v |= M_ARPC;
      1: v |= M_RD | M_IRLD | M_PCINC;
      2: v |= M_ARIR;
      3: if (d == 3'd7) v |= M_SC; else if (i) v |= M_RD | M_ARMEM;
      4: case (d)
           3'd0, 3'd1, 3'd2, 3'd6: v |= M_RD | M_DRLD;
           3'd3: v |= M_WR | M_SC;
           3'd4: v |= M_PCAR | M_SC;
           3'd5: v |= M_WR | M_ARINC;
           default: ;
         endcase
      5: case (d)
           3'd0, 3'd1, 3'd2: begin v |= M_ACLD | M_SC; v[1:0] = 2'(d + 3'd1); end
           3'd5: v |= M_PCAR | M_SC;
           3'd6: v |= M_DRINC;
           default: ;
         endcase
      6: if (d == 3'd6) v |= M_WR | M_SC | (drz ? M_PCINC : 17'd0);
      default: v |= M_SC;
    endcase
    return v;
  endfunction

  task automatic drive(input logic [7:0] tv, input logic [15:0] irv, input logic drz,
                       input logic st, input logic rst);
    t = tv; ir = irv; dr_zero = drz; start = st; reset = rst;
    @(negedge clk);
  endtask

  task automatic tick();
    logic ok, run;
    @(posedge clk);
    if (reset) begin
      ms = 1'b1; mi = 1'b0; md = 3'd0; me = 1'b0;
    end else begin
      ok = $onehot(t);
      run = ms && !me && ok;
      if (!ok) me = 1'b1;
      if (run && t[2]) begin mi = ir[15]; md = ir[14:12]; end
      if (run && t[3] && md == 3'd7 && !mi && ir[0]) ms = 1'b0;
      else if (!ms && start) ms = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(8'd1, 16'h0000, 1'b0, 1'b0, 1'b1);
    tick();
    drive(8'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
    compared++;
    if (obs !== M_ARPC) begin
      mismatched++;
      $display("FAIL reset_t0: got %b want %b", obs, M_ARPC);
    end
    tick();
  endtask

  task automatic test_lda();
    logic [16:0] tab [6];
    tab[0] = M_ARPC; tab[1] = M_RD | M_IRLD | M_PCINC; tab[2] = M_ARIR; tab[3] = 17'd0;
    tab[4] = M_RD | M_DRLD; tab[5] = M_ACLD | M_SC | 17'd3;
    for (int k = 0; k < 6; k++) begin
      drive(8'(1 << k), 16'h2123, 1'b0, 1'b0, 1'b0);
      compared++;
      if (obs !== tab[k]) begin
        mismatched++;
        $display("FAIL lda_t%0d: got %b want %b", k, obs, tab[k]);
      end
      tick();
    end
  endtask

  task automatic test_indirect();
    for (int k = 0; k < 4; k++) begin
      drive(8'(1 << k), 16'hA123, 1'b0, 1'b0, 1'b0);
      if (k == 3) begin
        compared++;
        if (obs !== (M_RD | M_ARMEM)) begin
          mismatched++;
          $display("FAIL indirect_t3: got %b want %b", obs, M_RD | M_ARMEM);
        end
      end
      tick();
    end
  endtask

  task automatic test_isz(input logic drz);
    logic [16:0] want;
    for (int k = 0; k < 7; k++) begin
      drive(8'(1 << k), 16'h6050, drz, 1'b0, 1'b0);
      want = (k == 5) ? M_DRINC : (M_WR | M_SC | (drz ? M_PCINC : 17'd0));
      if (k >= 5) begin
        compared++;
        if (obs !== want) begin
          mismatched++;
          $display("FAIL isz_t%0d_drz%0d: got %b want %b", k, drz, obs, want);
        end
      end
      tick();
    end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 4; k++) begin
      drive(8'(1 << k), 16'h7001, 1'b0, 1'b0, 1'b0);
      if (k == 3) begin
        compared++;
        if (obs !== M_SC) begin
          mismatched++;
          $display("FAIL hlt_t3: got %b want %b", obs, M_SC);
        end
      end
      tick();
    end
    drive(8'd1, 16'h7001, 1'b0, 1'b0, 1'b0);
    compared++;
    if (obs !== (M_SC | M_HALT)) begin
      mismatched++;
      $display("FAIL halted_t0: got %b want %b", obs, M_SC | M_HALT);
    end
    tick();
    drive(8'd1, 16'h7001, 1'b0, 1'b1, 1'b0);
    tick();
    drive(8'd1, 16'h7001, 1'b0, 1'b0, 1'b0);
    compared++;
    if (obs !== M_ARPC) begin
      mismatched++;
      $display("FAIL restart_t0: got %b want %b", obs, M_ARPC);
    end
    tick();
  endtask

  task automatic test_err();
    drive(8'b0000_0011, 16'h2123, 1'b0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(8'(1 << k), 16'h2123, 1'b1, 1'b1, 1'b0);
      compared++;
      if (obs !== (M_SC | M_ERR)) begin
        mismatched++;
        $display("FAIL err_sticky_t%0d: got %b want %b", k, obs, M_SC | M_ERR);
      end
      tick();
    end
    drive(8'd1, 16'h2123, 1'b0, 1'b0, 1'b1);
    tick();
    drive(8'd1, 16'h2123, 1'b0, 1'b0, 1'b0);
    compared++;
    if (obs !== M_ARPC) begin
      mismatched++;
      $display("FAIL err_cleared: got %b want %b", obs, M_ARPC);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      drive(8'(1 << k), 16'h6050, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(8'h10, 16'h6050, 1'b0, 1'b0, 1'b1);
    tick();
    drive(8'h08, 16'h6050, 1'b0, 1'b0, 1'b0);
    compared++;
    if (obs !== 17'd0) begin
      mismatched++;
      $display("FAIL rstmid_t3: got %b want %b", obs, 17'd0);
    end
    tick();
    drive(8'h20, 16'h6050, 1'b0, 1'b0, 1'b0);
    compared++;
    if (obs !== (M_ACLD | M_SC | 17'd1)) begin
      mismatched++;
      $display("FAIL rstmid_t5: got %b want %b", obs, M_ACLD | M_SC | 17'd1);
    end
    tick();
  endtask

  task automatic test_random();
    int k;
    logic [15:0] cur_ir;
    logic [7:0] tv;
    logic rst;
    logic [16:0] want;
    k = 0;
    cur_ir = 16'($urandom);
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 149) == 0) || (me && $urandom_range(0, 3) == 0);
      if (k == 0) cur_ir = 16'($urandom);
      if ($urandom_range(0, 99) == 0)
        tv = $urandom_range(0, 1) ? 8'h00 : 8'(8'h03 << $urandom_range(0, 6));
      else
        tv = 8'(1 << k);
      drive(tv, cur_ir, 1'($urandom), $urandom_range(0, 3) == 0, rst);
      want = exp_vec(ms, mi, me, md, t, dr_zero);
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL random_%0d t=%b ir=%h: got %b want %b", n, t, ir, obs, want);
      end
      tick();
      if (rst) k = 0;
      else if ($onehot(tv)) k = want[16] ? 0 : k + 1;
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_indirect();
    test_isz(1'b1);
    test_isz(1'b0);
    test_halt();
    test_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/timing_control_unit.md
TIMING_CONTROL_UNIT -- requirements
Module: timing_control_unit

Interface
REQ-001 SHALL have parameter IR_W, default 16, giving instruction width: I bit at [IR_W-1], opcode at [IR_W-2:IR_W-4], HLT bit at [0].
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port t  input  8  one-hot timing signals T0..T7 from the sequence counter decoder.
REQ-005 SHALL have port ir  input  IR_W  instruction register contents, valid from T2.
REQ-006 SHALL have port dr_zero  input  1  data register equals zero.
REQ-007 SHALL have port start  input  1  restart request while halted.
REQ-008 SHALL have outputs (each 1 bit): sc_clr (clear sequence counter), ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc, ir_ld, pc_inc, pc_ld_ar, mem_rd, mem_wr, dr_ld, dr_inc, ac_ld, halted, err.
REQ-009 SHALL have output alu_op  output  2  00 none, 01 AND, 10 ADD, 11 pass DR.

Function
REQ-010 SHALL hold registers: run flag S, indirect flag I, opcode D (3 bits), sticky err.
REQ-011 Control outputs SHALL be combinational from t, S, I, D, ir, dr_zero, err; zero-cycle latency relative to t.
REQ-012 SHALL assert only sc_clr while S=0 or err=1; all other control outputs 0.
REQ-013 T0: ar_ld_pc.  T1: mem_rd, ir_ld, pc_inc.  T2: ar_ld_ir; latch I<=ir[IR_W-1], D<=ir[IR_W-2:IR_W-4] at the clock edge ending T2.
REQ-014 T3, D=7: sc_clr; if I=0 and ir[0]=1 (HLT), S cleared at the clock edge ending T3.
REQ-015 T3, D!=7: if I=1, mem_rd and ar_ld_mem; else no outputs.
REQ-016 D=0 AND/1 ADD/2 LDA: T4 mem_rd, dr_ld; T5 ac_ld, alu_op 01/10/11 respectively, sc_clr.
REQ-017 D=3 STA: T4 mem_wr, sc_clr.  D=4 BUN: T4 pc_ld_ar, sc_clr.
REQ-018 D=5 BSA: T4 mem_wr, ar_inc; T5 pc_ld_ar, sc_clr.
REQ-019 D=6 ISZ: T4 mem_rd, dr_ld; T5 dr_inc; T6 mem_wr, sc_clr, pc_inc only if dr_zero=1.
REQ-020 T7 with S=1, err=0 SHALL assert sc_clr only (overrun guard).
REQ-021 t not one-hot (zero or multiple bits) SHALL set err at next edge; err sticky until reset.
REQ-022 start=1 while S=0 SHALL set S at next edge; start ignored while S=1; HLT and start in same cycle: HLT wins.
REQ-023 halted SHALL equal ~S; alu_op SHALL be 00 whenever ac_ld=0.

Reset
REQ-024 reset=1 SHALL set S=1, I=0, D=0, err=0 at the next edge; takes priority over all other updates.
REQ-025 Reset mid-instruction SHALL abandon the instruction; outputs follow REQ-013 from the next T0.

Structure
REQ-026 Opcode constants (AND..IO) and alu_op encodings SHALL live in a shared package cpu_ctrl_pkg.
REQ-027 Opcode decode SHALL be a sub-module opcode_decoder (3-bit D to 8 one-hot lines).

Verification
REQ-028 Reset, ir=16'h2123, walk T0..T5 -> ar_ld_pc; mem_rd/ir_ld/pc_inc; ar_ld_ir; none; mem_rd/dr_ld; ac_ld, alu_op=11, sc_clr.
REQ-029 ir=16'hA123, T3 -> mem_rd=1, ar_ld_mem=1; sc_clr=0.
REQ-030 ir=16'h6050, dr_zero=1 at T6 -> mem_wr=1, pc_inc=1, sc_clr=1; repeat with dr_zero=0 -> pc_inc=0.
REQ-031 ir=16'h7001 at T3 -> sc_clr=1, halted=1 next cycle; T0 afterwards -> only sc_clr; start=1 -> halted=0 next cycle.
REQ-032 t=8'b00000011 -> err=1 next cycle, sc_clr=1, all else 0; persists until reset.
REQ-033 reset asserted during T4 of ir=16'h6050 -> next cycle I=0, D=0, halted=0, err=0.
